// File: rtl/nonce_pkg.sv
// Shared nonce definitions: word width, secp256k1 group order and collector states.
package nonce_pkg;

    localparam int NONCE_W = 256;

    localparam logic [NONCE_W-1:0] SECP256K1_N =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_OFFER,
        ST_ISSUE,
        ST_FAULT
    } state_e;

    // A usable ECDSA nonce must lie in [1, N-1].
    function automatic logic in_range(input logic [NONCE_W-1:0] v);
        return (v != '0) && (v < SECP256K1_N);
    endfunction

endpackage

// File: rtl/entropy_rep_test.sv
// Repetition-count health test on the TRNG bit stream; trip is asserted
// combinationally alongside the valid bit that completes a run of REP_LIMIT.
module entropy_rep_test #(
    parameter int REP_LIMIT = 48,
    parameter int CNT_W     = $clog2(REP_LIMIT + 1) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_i,
    input  logic valid_i,
    input  logic clear_i,
    output logic trip_o
);

    logic [CNT_W-1:0] run_q, run_d, run_inc;
    logic             last_q, last_d;

    always_comb begin
        run_inc = (run_q != '0 && bit_i == last_q) ? run_q + CNT_W'(1) : CNT_W'(1);
        run_d   = run_q;
        last_d  = last_q;
        if (clear_i) begin
            run_d  = '0;
            last_d = 1'b0;
        end else if (valid_i) begin
            run_d  = run_inc;
            last_d = bit_i;
        end
    end

    assign trip_o = valid_i && !clear_i && (run_inc >= CNT_W'(REP_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            last_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/entropy_nonce_collector.sv
// Gathers 256 TRNG bits, rejection-samples against the secp256k1 order and issues
// each accepted nonce once. Define NONCE_HEALTH_TEST_EN to enable the repetition test.
module entropy_nonce_collector
    import nonce_pkg::*;
#(
    parameter int REP_LIMIT   = 48,
    parameter int MAX_REJECTS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               entropy_bit,
    input  logic               entropy_valid,
    input  logic               sink_busy,
    output logic [NONCE_W-1:0] nonce_out,
    output logic               nonce_valid,
    output logic               load_nonce,
    output logic               busy,
    output logic               fault
);

    localparam int RJ_W = $clog2(MAX_REJECTS + 1);

    state_e             state_q;
    logic [NONCE_W-1:0] shreg_q;
    logic [8:0]         bit_cnt_q;
    logic [RJ_W-1:0]    reject_cnt_q;
    logic               health_trip;

`ifdef NONCE_HEALTH_TEST_EN
    entropy_rep_test #(
        .REP_LIMIT(REP_LIMIT)
    ) u_rep_test (
        .clk     (clk),
        .rst     (rst),
        .bit_i   (entropy_bit),
        .valid_i (entropy_valid),
        .clear_i (state_q != ST_COLLECT),
        .trip_o  (health_trip)
    );
`else
    logic unused_rep_limit;
    assign unused_rep_limit = (REP_LIMIT > 0);
    assign health_trip      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            reject_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req) state_q <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    // The bit that trips the health test is dropped, not shifted in.
                    if (entropy_valid) begin
                        if (health_trip) begin
                            state_q <= ST_FAULT;
                        end else begin
                            shreg_q   <= {shreg_q[NONCE_W-2:0], entropy_bit};
                            bit_cnt_q <= bit_cnt_q + 9'd1;
                            if (bit_cnt_q == 9'd255) state_q <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (in_range(shreg_q)) begin
                        state_q      <= ST_OFFER;
                        reject_cnt_q <= '0;
                    end else begin
                        shreg_q      <= '0;
                        bit_cnt_q    <= '0;
                        reject_cnt_q <= reject_cnt_q + RJ_W'(1);
                        state_q      <= (reject_cnt_q == RJ_W'(MAX_REJECTS - 1)) ? ST_FAULT
                                                                                  : ST_COLLECT;
                    end
                end
                ST_OFFER: begin
                    if (!sink_busy) state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    shreg_q   <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= ST_IDLE;
                end
                ST_FAULT: begin
                    shreg_q   <= '0;
                    bit_cnt_q <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign nonce_valid = (state_q == ST_OFFER) || (state_q == ST_ISSUE);
    assign load_nonce  = (state_q == ST_ISSUE);
    assign fault       = (state_q == ST_FAULT);
    assign nonce_out   = nonce_valid ? shreg_q : '0;

endmodule

// File: tb/tb_entropy_nonce_collector.sv
// Directed bench for entropy_nonce_collector with a per-cycle reference model.
module tb_entropy_nonce_collector;

    localparam int TB_REP = 300;
    localparam int TB_MAX = 4;
    localparam logic [255:0] TB_N =
        256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
    localparam logic [255:0] PAT_AA = {32{8'hAA}};
    localparam logic [255:0] PAT_55 = {32{8'h55}};
    localparam logic [255:0] PAT_DB = {8{32'hDEADBEEF}};
    localparam logic [255:0] PAT_C3 = {16{16'h0FC3}};

    localparam int P_IDLE = 0, P_COLLECT = 1, P_CHECK = 2, P_OFFER = 3, P_ISSUE = 4, P_FAULT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic entropy_bit = 1'b0;
    logic entropy_valid = 1'b0;
    logic sink_busy = 1'b0;
    logic [255:0] nonce_out;
    logic nonce_valid, load_nonce, busy, fault;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    entropy_nonce_collector #(
        .REP_LIMIT(TB_REP),
        .MAX_REJECTS(TB_MAX)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .entropy_bit(entropy_bit), .entropy_valid(entropy_valid), .sink_busy(sink_busy),
        .nonce_out(nonce_out), .nonce_valid(nonce_valid), .load_nonce(load_nonce),
        .busy(busy), .fault(fault)
    );

`ifdef NONCE_HEALTH_TEST_EN
    logic [255:0] h_nonce_out;
    logic h_nonce_valid, h_load_nonce, h_busy, h_fault;

    entropy_nonce_collector dut_h (
        .clk(clk), .rst(rst), .req(req),
        .entropy_bit(entropy_bit), .entropy_valid(entropy_valid), .sink_busy(sink_busy),
        .nonce_out(h_nonce_out), .nonce_valid(h_nonce_valid), .load_nonce(h_load_nonce),
        .busy(h_busy), .fault(h_fault)
    );
`endif

    // Reference model: bits gathered in a queue, word formed and judged at CHECK.
    int  m_phase = P_IDLE;
    bit  m_bits[$];
    logic [255:0] m_nonce = '0;
    int  m_rej = 0;
    bit  model_ok = 1'b0;

    function automatic logic [255:0] pack_bits();
        logic [255:0] v = '0;
        foreach (m_bits[i]) v = {v[254:0], m_bits[i]};
        return v;
    endfunction

    function automatic bit rep_trip(input bit b);
`ifdef NONCE_HEALTH_TEST_EN
        int run = 1;
        for (int i = m_bits.size() - 1; i >= 0 && m_bits[i] == b; i--) run++;
        return run >= TB_REP;
`else
        return b & 1'b0;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_phase = P_IDLE;
                m_bits.delete();
                m_nonce = '0;
                m_rej = 0;
                model_ok = 1'b1;
            end else begin
                case (m_phase)
                    P_IDLE: if (req) m_phase = P_COLLECT;
                    P_COLLECT: if (entropy_valid) begin
                        if (rep_trip(entropy_bit)) m_phase = P_FAULT;
                        else begin
                            m_bits.push_back(entropy_bit);
                            if (m_bits.size() == 256) m_phase = P_CHECK;
                        end
                    end
                    P_CHECK: begin
                        m_nonce = pack_bits();
                        if (m_nonce != '0 && m_nonce < TB_N) begin
                            m_phase = P_OFFER;
                            m_rej = 0;
                        end else begin
                            m_rej++;
                            m_bits.delete();
                            m_nonce = '0;
                            m_phase = (m_rej >= TB_MAX) ? P_FAULT : P_COLLECT;
                        end
                    end
                    P_OFFER: if (!sink_busy) m_phase = P_ISSUE;
                    P_ISSUE: begin
                        m_bits.delete();
                        m_nonce = '0;
                        m_phase = P_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                logic e_busy, e_valid, e_load, e_fault;
                logic [255:0] e_out;
                e_busy  = (m_phase != P_IDLE);
                e_valid = (m_phase == P_OFFER) || (m_phase == P_ISSUE);
                e_load  = (m_phase == P_ISSUE);
                e_fault = (m_phase == P_FAULT);
                e_out   = e_valid ? m_nonce : '0;
                checks++;
                if (busy !== e_busy || nonce_valid !== e_valid || load_nonce !== e_load ||
                    fault !== e_fault || nonce_out !== e_out) begin
                    errors++;
                    $display("FAIL model_cmp cyc=%0d busy=%b/%b valid=%b/%b load=%b/%b fault=%b/%b out=%h exp=%h",
                             cyc, busy, e_busy, nonce_valid, e_valid, load_nonce, e_load,
                             fault, e_fault, nonce_out, e_out);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic feed_word(input logic [255:0] w, input int gap_every);
        for (int i = 255; i >= 0; i--) begin
            if (gap_every > 0 && (i % gap_every) == 0) begin
                entropy_valid = 1'b0;
                tick();
            end
            entropy_valid = 1'b1;
            entropy_bit   = w[i];
            tick();
        end
        entropy_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    initial begin
        tick();
        do_reset();
        settle();
        chk("reset_busy", 256'(busy), 256'd0);
        chk("reset_out", nonce_out, 256'd0);
        chk("reset_valid_load_fault", {253'd0, nonce_valid, load_nonce, fault}, 256'd0);

        // Alternating pattern, nominal latency; stray entropy in IDLE is discarded.
        entropy_valid = 1'b1; entropy_bit = 1'b1; tick(); entropy_valid = 1'b0;
        start_req();
        feed_word(PAT_AA, 0);
        settle(); chk("t1_c257_valid", 256'(nonce_valid), 256'd0);
        tick(); settle(); chk("t1_c258_valid", 256'(nonce_valid), 256'd1);
        chk("t1_c258_load", 256'(load_nonce), 256'd0);
        tick(); settle(); chk("t1_c259_load", 256'(load_nonce), 256'd1);
        chk("t1_c259_out", nonce_out, PAT_AA);
        tick(); settle(); chk("t1_c260_out", nonce_out, 256'd0);
        chk("t1_c260_load", 256'(load_nonce), 256'd0);
        chk("t1_c260_busy", 256'(busy), 256'd0);

        // Zero word rejected, then 0x55.. accepted: issue at 516.
        tick();
        start_req();
        feed_word(256'd0, 0);
        tick();
        feed_word(PAT_55, 0);
        tick(); tick(); settle();
        chk("t2_c516_load", 256'(load_nonce), 256'd1);
        chk("t2_c516_out", nonce_out, PAT_55);
        tick(); tick();

        // Four candidates equal to N: fault after the fourth CHECK.
        start_req();
        for (int k = 0; k < 4; k++) begin
            feed_word(TB_N, 0);
            settle(); chk("t3_check_fault", 256'(fault), 256'd0);
            tick();
        end
        settle();
        chk("t3_fault", 256'(fault), 256'd1);
        chk("t3_valid", 256'(nonce_valid), 256'd0);
        repeat (5) tick();
        settle(); chk("t3_fault_sticky", 256'(fault), 256'd1);
        tick();
        do_reset();
        settle(); chk("t3_rst_fault", 256'(fault), 256'd0);

`ifdef NONCE_HEALTH_TEST_EN
        // 48 consecutive ones trip the default-limit health test.
        tick();
        start_req();
        for (int i = 1; i <= 48; i++) begin
            entropy_valid = 1'b1;
            entropy_bit   = 1'b1;
            if (i == 48) begin
                settle(); chk("t4_c48_fault", 256'(h_fault), 256'd0);
            end
            tick();
        end
        entropy_valid = 1'b0;
        settle();
        chk("t4_c49_fault", 256'(h_fault), 256'd1);
        chk("t4_c49_valid", 256'(h_nonce_valid), 256'd0);
        chk("t4_c49_out", h_nonce_out, 256'd0);
        tick();
        do_reset();
        settle();
        chk("t4_rst_fault", 256'(h_fault), 256'd0);
        chk("t4_rst_busy", 256'(h_busy), 256'd0);
`endif

        // Backpressure in OFFER, with entropy gaps during collection.
        tick();
        start_req();
        feed_word(PAT_DB, 37);
        sink_busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(); settle();
            chk("t5_hold_valid", 256'(nonce_valid), 256'd1);
            chk("t5_hold_load", 256'(load_nonce), 256'd0);
        end
        sink_busy = 1'b0;
        tick(); settle();
        chk("t5_load", 256'(load_nonce), 256'd1);
        chk("t5_out", nonce_out, PAT_DB);
        tick(); settle();
        chk("t5_load_single", 256'(load_nonce), 256'd0);

        // Reset mid-collection, then a full fresh word with req held high.
        tick();
        start_req();
        for (int i = 255; i > 155; i--) begin
            entropy_valid = 1'b1;
            entropy_bit   = PAT_C3[i];
            tick();
        end
        entropy_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        settle();
        chk("t6_rst_busy", 256'(busy), 256'd0);
        chk("t6_rst_out", nonce_out, 256'd0);
        chk("t6_rst_flags", {253'd0, nonce_valid, load_nonce, fault}, 256'd0);
        req = 1'b1;
        tick();
        feed_word(PAT_C3, 0);
        settle(); chk("t6_c257_valid", 256'(nonce_valid), 256'd0);
        tick(); settle(); chk("t6_c258_valid", 256'(nonce_valid), 256'd1);
        tick(); settle(); chk("t6_c259_out", nonce_out, PAT_C3);
        tick(); settle(); chk("t6_c260_busy", 256'(busy), 256'd0);
        tick(); settle(); chk("t6_c261_busy", 256'(busy), 256'd1);
        req = 1'b0;
        tick();
        do_reset();

        // Largest valid nonce N-1 is accepted.
        tick();
        start_req();
        feed_word(TB_N - 256'd1, 0);
        tick(); tick(); settle();
        chk("t7_load", 256'(load_nonce), 256'd1);
        chk("t7_out", nonce_out, TB_N - 256'd1);
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
